// File: rtl/multi_buffer_pkg.sv
// multi_buffer_pkg: shared arbiter state encoding, event source indices and clog2 helper
package multi_buffer_pkg;
  typedef enum logic [2:0] {S_IDLE, S_WR_REQ, S_RD_REQ, S_WR_FIN, S_RD_FIN, S_WAIT_LOW} state_t;
  localparam int SRC_WR_REQ = 0;
  localparam int SRC_RD_REQ = 1;
  localparam int SRC_WR_FIN = 2;
  localparam int SRC_RD_FIN = 3;
  localparam int SRC_NUM = 4;
  function automatic int clog2(input int v);
    int r = 0;
    for (int i = 0; i < 31; i++) if ((1 << i) < v) r = i + 1;
    return r;
  endfunction
endpackage

// File: rtl/mbc_rr_arbiter.sv
// mbc_rr_arbiter: 4-way round-robin selector with rotating priority pointer
module mbc_rr_arbiter
  import multi_buffer_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [3:0] req,
  input  logic       adv,
  output logic [3:0] gnt
);
  logic [1:0] ptr, nxt;
  // first requester at or after ptr wins; descending loop lets the nearest one overwrite
  always_comb begin
    gnt = '0;
    nxt = ptr;
    for (int i = SRC_NUM - 1; i >= 0; i--)
      if (req[2'(ptr + 2'(i))]) begin
        gnt = 4'(1) << (ptr + 2'(i));
        nxt = ptr + 2'(i) + 2'd1;
      end
  end
  // pointer moves past the winner only when a grant is actually taken
  always_ff @(posedge clk_i)
    if (rst_i) ptr <= 2'(SRC_WR_REQ);
    else if (adv && |gnt) ptr <= nxt;
endmodule

// File: rtl/multi_buffer_controller.sv
// multi_buffer_controller: N-buffer ring with 4-phase writer/reader ownership handshakes
module multi_buffer_controller
  import multi_buffer_pkg::*;
#(
  parameter int WRITE_DATA_WIDTH = 8,
  parameter int WRITE_ADDR_WIDTH = 8,
  parameter int READ_DATA_WIDTH  = 8,
  parameter int READ_ADDR_WIDTH  = 8,
  parameter int BUFFER_NUM       = 4,
  parameter int OVERWRITE_MODE   = 0,
  localparam int BUF_W = clog2(BUFFER_NUM),
  localparam int CNT_W = clog2(BUFFER_NUM + 1)
) (
  input  logic                                clk_i,
  input  logic                                rst_i,
  input  logic                                wr_req_i,
  output logic                                wr_req_ack_o,
  output logic                                wr_req_result_o,
  input  logic                                wr_finish_i,
  output logic                                wr_finish_ack_o,
  input  logic                                wr_en_i,
  input  logic [WRITE_DATA_WIDTH-1:0]         wr_data_i,
  input  logic [WRITE_ADDR_WIDTH-1:0]         wr_addr_i,
  input  logic                                rd_req_i,
  output logic                                rd_req_ack_o,
  output logic                                rd_req_result_o,
  input  logic                                rd_finish_i,
  output logic                                rd_finish_ack_o,
  output logic [READ_DATA_WIDTH-1:0]          rd_data_o,
  input  logic [READ_ADDR_WIDTH-1:0]          rd_addr_i,
  output logic [CNT_W-1:0]                    full_cnt_o,
  output logic                                full_o,
  output logic                                empty_o,
  output logic [15:0]                         drop_cnt_o,
  output logic                                err_o,
  output logic                                ram_clk_o,
  output logic                                ram_rst_o,
  output logic                                ram_wr_en_o,
  output logic [WRITE_DATA_WIDTH-1:0]         ram_wr_data_o,
  output logic [BUF_W+WRITE_ADDR_WIDTH-1:0]   ram_wr_addr_o,
  input  logic [READ_DATA_WIDTH-1:0]          ram_rd_data_i,
  output logic [BUF_W+READ_ADDR_WIDTH-1:0]    ram_rd_addr_o
);
  localparam logic [BUF_W-1:0] LAST = BUF_W'(BUFFER_NUM - 1);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(BUFFER_NUM);
  state_t state, state_nxt;
  logic [BUF_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] full_cnt;
  logic [15:0] drop_cnt;
  logic wr_own, rd_own, err, wr_res, rd_res;
  logic [3:0] req, ack, gnt, sel;
  logic overwrite;
  function automatic logic [BUF_W-1:0] inc_ptr(input logic [BUF_W-1:0] p);
    return p == LAST ? '0 : p + 1'b1;
  endfunction
  assign req = {rd_finish_i, wr_finish_i, rd_req_i, wr_req_i};
  assign overwrite = OVERWRITE_MODE != 0 && !wr_own && full_cnt == FULL && !rd_own;
  mbc_rr_arbiter u_arb (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .req(req & ~ack),
    .adv(state == S_IDLE),
    .gnt(gnt)
  );
  // pick the granted event in IDLE, serve it for one cycle, then hold until its input drops
  always_comb begin
    state_nxt = state == S_IDLE ? (gnt[SRC_WR_REQ] ? S_WR_REQ : gnt[SRC_RD_REQ] ? S_RD_REQ :
                                   gnt[SRC_WR_FIN] ? S_WR_FIN : gnt[SRC_RD_FIN] ? S_RD_FIN : S_IDLE) :
                state == S_WAIT_LOW ? (|(req & sel) ? S_WAIT_LOW : S_IDLE) : S_WAIT_LOW;
  end
  // arbiter state register
  always_ff @(posedge clk_i)
    if (rst_i) state <= S_IDLE;
    else state <= state_nxt;
  // ownership, ring pointers, counters and handshake outputs
  always_ff @(posedge clk_i)
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      full_cnt <= '0;
      drop_cnt <= '0;
      wr_own <= 1'b0;
      rd_own <= 1'b0;
      err <= 1'b0;
      wr_res <= 1'b0;
      rd_res <= 1'b0;
      ack <= '0;
      sel <= '0;
    end else begin
      if (state == S_IDLE) sel <= gnt;
      case (state)
        S_WR_REQ: begin
          ack[SRC_WR_REQ] <= 1'b1;
          wr_res <= wr_own | (full_cnt != FULL) | overwrite;
          wr_own <= wr_own | (full_cnt != FULL) | overwrite;
          if (overwrite) begin
            rd_ptr <= inc_ptr(rd_ptr);
            full_cnt <= full_cnt - 1'b1;
            drop_cnt <= drop_cnt + {15'd0, drop_cnt != '1};
          end
        end
        S_RD_REQ: begin
          ack[SRC_RD_REQ] <= 1'b1;
          rd_res <= rd_own | (full_cnt != '0);
          rd_own <= rd_own | (full_cnt != '0);
        end
        S_WR_FIN: begin
          ack[SRC_WR_FIN] <= 1'b1;
          if (wr_own) begin
            wr_ptr <= inc_ptr(wr_ptr);
            full_cnt <= full_cnt + 1'b1;
            wr_own <= 1'b0;
          end else err <= 1'b1;
        end
        S_RD_FIN: begin
          ack[SRC_RD_FIN] <= 1'b1;
          if (rd_own) begin
            rd_ptr <= inc_ptr(rd_ptr);
            full_cnt <= full_cnt - 1'b1;
            rd_own <= 1'b0;
          end else err <= 1'b1;
        end
        S_WAIT_LOW:
          if (!(|(req & sel))) begin
            ack <= '0;
            wr_res <= 1'b0;
            rd_res <= 1'b0;
          end
        default: ;
      endcase
    end
  assign wr_req_ack_o    = ack[SRC_WR_REQ];
  assign rd_req_ack_o    = ack[SRC_RD_REQ];
  assign wr_finish_ack_o = ack[SRC_WR_FIN];
  assign rd_finish_ack_o = ack[SRC_RD_FIN];
  assign wr_req_result_o = wr_res;
  assign rd_req_result_o = rd_res;
  assign full_cnt_o      = full_cnt;
  assign full_o          = full_cnt == FULL;
  assign empty_o         = full_cnt == '0;
  assign drop_cnt_o      = drop_cnt;
  assign err_o           = err;
  assign ram_clk_o       = clk_i;
  assign ram_rst_o       = rst_i;
  assign ram_wr_en_o     = wr_en_i & wr_own;
  assign ram_wr_data_o   = wr_data_i;
  assign ram_wr_addr_o   = {wr_ptr, wr_addr_i};
  assign ram_rd_addr_o   = {rd_ptr, rd_addr_i};
  assign rd_data_o       = ram_rd_data_i;
endmodule

// File: tb/tb_multi_buffer_controller.sv
// tb_multi_buffer_controller: scoreboard bench for a 3-buffer controller, plain and overwrite flavours
module tb_multi_buffer_controller;
  logic clk = 1'b0, rst = 1'b1;
  logic wr_req = 0, wr_finish = 0, wr_en = 0, rd_req = 0, rd_finish = 0;
  logic [7:0] wr_data = 0, wr_addr = 0, rd_addr = 0, ram_rd_data = 0;
  logic wr_req_ack[2], wr_req_res[2], wr_fin_ack[2], rd_req_ack[2], rd_req_res[2], rd_fin_ack[2];
  logic full[2], empty[2], err[2], ram_clk[2], ram_rst[2], ram_wr_en[2];
  logic [1:0] full_cnt[2];
  logic [15:0] drop[2];
  logic [7:0] rd_data[2], ram_wr_data[2];
  logic [9:0] ram_wr_addr[2], ram_rd_addr[2];
  logic [3:0] ackv[2];
  typedef struct { int src; bit res; int fc; int dc; bit er; } exp_t;
  exp_t q[$];
  exp_t ex;
  int tests = 0, fails = 0, sel = 0;
  logic [3:0] prev = '0;
  logic r;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    multi_buffer_controller #(.BUFFER_NUM(3), .OVERWRITE_MODE(g)) u_dut (
      .clk_i(clk), .rst_i(rst),
      .wr_req_i(wr_req), .wr_req_ack_o(wr_req_ack[g]), .wr_req_result_o(wr_req_res[g]),
      .wr_finish_i(wr_finish), .wr_finish_ack_o(wr_fin_ack[g]),
      .wr_en_i(wr_en), .wr_data_i(wr_data), .wr_addr_i(wr_addr),
      .rd_req_i(rd_req), .rd_req_ack_o(rd_req_ack[g]), .rd_req_result_o(rd_req_res[g]),
      .rd_finish_i(rd_finish), .rd_finish_ack_o(rd_fin_ack[g]),
      .rd_data_o(rd_data[g]), .rd_addr_i(rd_addr),
      .full_cnt_o(full_cnt[g]), .full_o(full[g]), .empty_o(empty[g]),
      .drop_cnt_o(drop[g]), .err_o(err[g]),
      .ram_clk_o(ram_clk[g]), .ram_rst_o(ram_rst[g]), .ram_wr_en_o(ram_wr_en[g]),
      .ram_wr_data_o(ram_wr_data[g]), .ram_wr_addr_o(ram_wr_addr[g]),
      .ram_rd_data_i(ram_rd_data), .ram_rd_addr_o(ram_rd_addr[g])
    );
    assign ackv[g] = {rd_fin_ack[g], wr_fin_ack[g], rd_req_ack[g], wr_req_ack[g]};
  end

  // monitor: every rising ack of the watched instance pops one expected event
  always @(negedge clk) begin
    for (int s = 0; s < 4; s++)
      if (ackv[sel][s] && !prev[s]) begin
        tests++;
        if (q.size() == 0) begin
          fails++;
          $display("FAIL sb_unexpected ack src=%0d with nothing expected", s);
        end else begin
          ex = q.pop_front();
          r = s == 0 ? wr_req_res[sel] : rd_req_res[sel];
          if (s != ex.src || (s < 2 && r != ex.res) || int'(full_cnt[sel]) != ex.fc ||
              int'(drop[sel]) != ex.dc || err[sel] != ex.er) begin
            fails++;
            $display("FAIL sb_event got src=%0d res=%0b fc=%0d dc=%0d err=%0b exp src=%0d res=%0b fc=%0d dc=%0d err=%0b",
                     s, r, full_cnt[sel], drop[sel], err[sel], ex.src, ex.res, ex.fc, ex.dc, ex.er);
          end
        end
      end
    prev = ackv[sel];
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic chk(string name, longint got, longint exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  task automatic set_in(int s, bit v);
    case (s)
      0: wr_req = v;
      1: rd_req = v;
      2: wr_finish = v;
      default: rd_finish = v;
    endcase
  endtask

  task automatic push(int s, bit res, int fc, int dc, bit er);
    exp_t e;
    e.src = s; e.res = res; e.fc = fc; e.dc = dc; e.er = er;
    q.push_back(e);
  endtask

  task automatic wait_ack(int s, bit v, output int n);
    n = 0;
    while (ackv[sel][s] !== v && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (ackv[sel][s] !== v) begin
      tests++;
      fails++;
      $display("FAIL ack_timeout src=%0d got=%0b exp=%0b", s, ackv[sel][s], v);
    end
  endtask

  task automatic hs(int s, bit res, int fc, int dc, bit er);
    int n;
    push(s, res, fc, dc, er);
    set_in(s, 1'b1);
    wait_ack(s, 1'b1, n);
    chk($sformatf("latency_src%0d", s), n, 2);
    set_in(s, 1'b0);
    wait_ack(s, 1'b0, n);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("ram_rst", ram_rst[sel], 1);
    chk("ram_clk", ram_clk[sel], clk);
    rst = 1'b0;
  endtask

  initial begin
    int n;
    do_reset();
    chk("rst_acks", ackv[0], 0);
    chk("rst_results", {wr_req_res[0], rd_req_res[0]}, 0);
    chk("rst_full_cnt", full_cnt[0], 0);
    chk("rst_flags", {full[0], empty[0], err[0]}, 3'b010);
    chk("rst_drop", drop[0], 0);
    wr_addr = 8'h3c;
    wr_data = 8'ha5;
    for (int i = 0; i < 3; i++) begin
      chk("wr_ptr", ram_wr_addr[0][9:8], i);
      hs(0, 1'b1, i, 0, 1'b0);
      wr_en = 1'b1;
      #1;
      chk("wr_en_owned", ram_wr_en[0], 1);
      chk("wr_data", ram_wr_data[0], 8'ha5);
      wr_en = 1'b0;
      hs(2, 1'b0, i + 1, 0, 1'b0);
    end
    chk("wr_ptr_wrap", ram_wr_addr[0], 10'h03c);
    chk("full_flags", {full[0], empty[0], full_cnt[0]}, 4'b1011);
    hs(0, 1'b0, 3, 0, 1'b0);
    rd_addr = 8'h5a;
    ram_rd_data = 8'hc3;
    hs(1, 1'b1, 3, 0, 1'b0);
    chk("rd_addr_first", ram_rd_addr[0], 10'h05a);
    chk("rd_data", rd_data[0], 8'hc3);
    hs(3, 1'b0, 2, 0, 1'b0);
    chk("rd_ptr_after_fin", ram_rd_addr[0], 10'h15a);
    hs(2, 1'b0, 2, 0, 1'b1);
    wr_en = 1'b1;
    #1;
    chk("wr_en_unowned", ram_wr_en[0], 0);
    chk("err_sticky", err[0], 1);
    wr_en = 1'b0;
    // simultaneous wr_finish and rd_req with the rotating pointer at WR_REQ
    do_reset();
    push(1, 1'b0, 0, 0, 1'b0);
    push(2, 1'b0, 0, 0, 1'b1);
    wr_finish = 1'b1;
    rd_req = 1'b1;
    wait_ack(1, 1'b1, n);
    chk("rr_rd_first_latency", n, 2);
    chk("rr_wfin_waits", ackv[0][2], 0);
    rd_req = 1'b0;
    wait_ack(1, 1'b0, n);
    chk("rr_wfin_still_waits", ackv[0][2], 0);
    wait_ack(2, 1'b1, n);
    chk("rr_wfin_latency", n, 2);
    wr_finish = 1'b0;
    wait_ack(2, 1'b0, n);
    // reset pulse in the middle of a read-request handshake
    do_reset();
    push(1, 1'b0, 0, 0, 1'b0);
    rd_req = 1'b1;
    wait_ack(1, 1'b1, n);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_acks", ackv[0], 0);
    chk("midrst_state", {rd_req_res[0], err[0], full_cnt[0], empty[0]}, 5'b00001);
    chk("midrst_drop", drop[0], 0);
    push(1, 1'b0, 0, 0, 1'b0);
    rst = 1'b0;
    wait_ack(1, 1'b1, n);
    chk("reack_latency", n, 2);
    rd_req = 1'b0;
    wait_ack(1, 1'b0, n);
    // overwrite-mode instance
    rst = 1'b1;
    sel = 1;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      hs(0, 1'b1, i, 0, 1'b0);
      hs(2, 1'b0, i + 1, 0, 1'b0);
    end
    chk("ovw_full", full[1], 1);
    hs(0, 1'b1, 2, 1, 1'b0);
    chk("ovw_rd_ptr", ram_rd_addr[1][9:8], 1);
    chk("ovw_drop", drop[1], 1);
    hs(2, 1'b0, 3, 1, 1'b0);
    hs(1, 1'b1, 3, 1, 1'b0);
    hs(0, 1'b0, 3, 1, 1'b0);
    hs(3, 1'b0, 2, 1, 1'b0);
    chk("ovw_rd_ptr_after_fin", ram_rd_addr[1][9:8], 2);
    @(negedge clk);
    chk("sb_drained", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
